pattern_detector: RTL
=====================

Name: pattern_detector

Overview:
- Programmable serial bit-pattern detector; the parametrised successor to the fixed 4-bit sequence detector FSM.
- Matches a runtime-configurable pattern of 1..PAT_W bits, with a per-bit don't-care mask, overlap/non-overlap mode, input qualification and a saturating match counter.
- Sits on a serial bit stream (framing/sync-word search) and feeds a one-cycle detect pulse to downstream control.

Parameters:
- PAT_W, 8, maximum pattern length in bits; legal range 4..32.
- CNT_W, 16, width of the saturating match counter; legal range 1..32.
- LEN_W, derived (not overridable), $clog2(PAT_W+1), width of length fields.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_bit; the bit is sampled only when in_valid=1.
- in_bit  input  1  serial data bit.
- cfg_we  input  1  one-cycle configuration write strobe.
- cfg_pattern  input  PAT_W  pattern; bit [len-1] = first-received bit, bit 0 = last-received bit.
- cfg_mask  input  PAT_W  1 = compare this bit, 0 = don't care; same bit alignment as cfg_pattern.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
- count_clr  input  1  clears match_count.
- detected  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  number of matches, saturating.
- fill  output  LEN_W  number of valid history bits, saturating at the active length.

Behaviour:
- Reset (rst=1 at a clock edge):
  - detected=0, match_count=0, history=0, fill=0.
  - Config registers set to: pattern=...0001101 (1101 zero-extended), mask=all ones, len=4, overlap=1.
  - Reset overrides every other input.
- Config write (cfg_we=1):
  - Loads pattern, mask, len and overlap registers.
  - Clears history and fill; detected=0 next cycle.
  - match_count is not changed.
  - Any in_valid bit in the same cycle is discarded.
- Length clamping:
  - cfg_len > PAT_W is stored as PAT_W.
  - cfg_len = 0 is stored as 0 and disables matching (detected never asserts, fill stays 0).
- Sampling (in_valid=1, no cfg_we):
  - hist_next = {hist[PAT_W-2:0], in_bit}.
  - fill_next = min(fill+1, len).
- Match condition, evaluated on hist_next and fill_next:
  - fill_next == len, len != 0, and ((hist_next ^ pattern) & mask & lenmask) == 0.
  - lenmask = low len bits set.
- Latency: detected=1 during exactly the one cycle following the edge that accepted the completing bit; it is 0 in all other cycles.
  - in_valid=0 cycles hold history and fill, and leave detected=0.
- Overlap mode: after a match, history and fill are kept, so the next bit can complete a new match.
- Non-overlap mode: on a match, history and fill clear to 0 at the same edge. A new match needs len fresh bits.
- match_count:
  - Increments by 1 on each match edge; saturates at 2^CNT_W-1 with no wrap.
  - count_clr sets it to 0; if a match occurs at the same edge, clear wins and the result is 0. detected still pulses.
- Reset mid-pattern: a partial history is discarded; a pattern straddling the reset is never detected.
- Mask edge case: a mask of all zeros over len bits matches whenever fill reaches len. In overlap mode this gives one pulse per valid bit.

Test Plan:
- Reset defaults, overlap, stream 1,1,0,1,1,0,1 (in_valid=1 continuously) -> detected pulses after bits 4 and 7; match_count=2.
- Same stream after cfg_we with overlap=0, pattern 1101, len 4 -> single pulse after bit 4; match_count increments by 1; fill=3 at end.
- pattern=0b1001, mask=0b1011, len=4 (bit 2 don't-care); streams 1,0,0,1 and 1,1,0,1 -> each produces one pulse; stream 1,0,1,1 -> no pulse.
- Reset defaults; 1,1,0 with in_valid gaps of 3 idle cycles, then 1 -> one pulse after the final valid bit; rst asserted after 1,1,0 then 1 -> no pulse.
- CNT_W=2, repeated 1101 overlap matches x5 -> match_count 1,2,3,3,3; count_clr coincident with a match -> match_count=0 while detected=1.
- cfg_len=15 with PAT_W=8 -> stored len=8, 8-bit match works; cfg_len=0 -> no pulse for 20 random bits; cfg_we coincident with in_valid -> bit ignored, fill=0.

Source files
------------

// File: rtl/pattern_detector.sv
// Programmable serial bit-pattern detector with a runtime pattern, a per-bit compare mask,
// overlap/non-overlap matching and a saturating match counter.
module pattern_detector #(
    parameter  int unsigned PAT_W = 8,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] fill
);

    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_DEFAULT = LEN_W'(4);
    localparam logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1101);

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;
    // The oldest history bit is never compared, so only PAT_W-1 bits are kept.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             det_q,  det_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic [PAT_W-1:0] hist_nx;
    logic [LEN_W-1:0] fill_nx;
    logic [PAT_W-1:0] lenmask;
    logic             sample_c;
    logic             match_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_DEFAULT;
            mask_q <= '1;
            len_q  <= LEN_DEFAULT;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            mask_q <= mask_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
        end
    end

    // Candidate history/fill for an accepted bit; the match is judged on these values.
    always_comb begin
        hist_nx  = {hist_q, in_bit};
        fill_nx  = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            lenmask[i] = (32'(i) < 32'(len_q));
        end
        sample_c = in_valid && !cfg_we;
        match_c  = sample_c && (len_q != '0) && (fill_nx == len_q) &&
                   (((hist_nx ^ pat_q) & mask_q & lenmask) == '0);
    end

    always_comb begin
        pat_d  = pat_q;
        mask_d = mask_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_we) begin
            pat_d  = cfg_pattern;
            mask_d = cfg_mask;
            len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (sample_c) begin
            if (match_c && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_nx[PAT_W-2:0];
                fill_d = fill_nx;
            end
        end

        det_d = match_c;

        // Clear takes priority over a coincident match.
        if (count_clr) begin
            cnt_d = '0;
        end else if (match_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign detected    = det_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule
